// File: rtl/i2c_rx_buffer.sv
// -----------------------------------------------------------------------------
// i2c_rx_buffer
//
// Byte buffer sitting directly behind the I2C master receiver. Every byte the
// receiver strobes out is captured into a show-ahead FIFO together with a flag
// marking the last byte of its frame. A local consumer drains the FIFO through
// a valid/ready port.
//
// Ports:
//   clk, rst_n       single clock (rising edge), synchronous active-low reset
//   i2c_ready        receiver start; its rising edge begins a new frame
//   i2c_data_bytes   bytes per frame, sampled on the i2c_ready rising edge
//   i2c_data         received byte
//   i2c_data_valid   one-cycle strobe qualifying i2c_data
//   rd_ready         consumer accepts the head entry
//   rd_valid         head entry present (not empty)
//   rd_data/rd_last  head byte and its end-of-frame flag (combinational read)
//   ovf_clr          clears the sticky overflow flag
//   level            entries held, 0..DEPTH
//   full / empty     level == DEPTH / level == 0
//   overflow         sticky: a byte arrived while full and was dropped
//   frame_done       one-cycle pulse after the last byte of a frame is stored
// -----------------------------------------------------------------------------
module i2c_rx_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i2c_ready,
    input  logic [3:0]    i2c_data_bytes,
    input  logic [7:0]    i2c_data,
    input  logic          i2c_data_valid,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic          rd_last,
    input  logic          ovf_clr,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          frame_done
);

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } entry_t;

    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    entry_t        mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rdy_prev_q, rdy_prev_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    fcnt_q, fcnt_d;
    logic          ovf_q, ovf_d;
    logic          fd_q, fd_d;

    logic          rise;
    logic [3:0]    fcnt_cur;
    logic          is_last;
    logic          wr_en;
    logic          drop;
    logic          pop;

    // Status decoded from the count register.
    assign full     = (count_q == DEPTH_L);
    assign empty    = (count_q == '0);
    assign rd_valid = ~empty;
    assign level    = count_q;
    assign overflow = ovf_q;
    assign frame_done = fd_q;

    // Show-ahead head: combinational read at the read pointer.
    assign rd_data = mem_q[rd_ptr_q].data;
    assign rd_last = mem_q[rd_ptr_q].last;

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves a value unassigned and no latch can be inferred.
    always_comb begin
        rise       = i2c_ready & ~rdy_prev_q;
        rdy_prev_d = i2c_ready;

        // A frame start in the same cycle as a strobe takes effect first:
        // the incoming byte is byte 0 of the new frame.
        len_d    = rise ? i2c_data_bytes : len_q;
        fcnt_cur = rise ? 4'd0 : fcnt_q;
        is_last  = (len_d != 4'd0) && ((fcnt_cur + 4'd1) == len_d);

        // Full is strict: a pop in the same cycle does not make room.
        wr_en = i2c_data_valid & ~full;
        drop  = i2c_data_valid & full;
        pop   = rd_valid & rd_ready;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The frame counter advances on every strobe, dropped or not, so a
        // lost byte does not shift the tagging of later frames.
        fcnt_d = fcnt_cur;
        if (i2c_data_valid) begin
            fcnt_d = is_last ? 4'd0 : fcnt_cur + 4'd1;
        end

        // A dropped last byte is neither tagged nor announced.
        fd_d = wr_en & is_last;

        // Set has priority over clear.
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rdy_prev_q <= 1'b0;
            len_q      <= 4'd0;
            fcnt_q     <= 4'd0;
            ovf_q      <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rdy_prev_q <= rdy_prev_d;
            len_q      <= len_d;
            fcnt_q     <= fcnt_d;
            ovf_q      <= ovf_d;
            fd_q       <= fd_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only meaningful while
    // the count covers them, so clearing it would cost logic for no benefit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= '{last: is_last, data: i2c_data};
        end
    end

endmodule

// File: tb/tb_i2c_rx_buffer.sv
// -----------------------------------------------------------------------------
// tb_i2c_rx_buffer
//
// Directed scenarios followed by a randomized phase. A queue-based reference
// model tracks FIFO contents, frame position, overflow and frame_done; every
// cycle the DUT outputs are compared with it, and directed steps add explicit
// expected constants.
// -----------------------------------------------------------------------------
module tb_i2c_rx_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i2c_ready;
    logic [3:0]    i2c_data_bytes;
    logic [7:0]    i2c_data;
    logic          i2c_data_valid;
    logic          rd_ready;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          rd_last;
    logic          ovf_clr;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          frame_done;

    always #5 clk = ~clk;

    i2c_rx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i2c_ready      (i2c_ready),
        .i2c_data_bytes (i2c_data_bytes),
        .i2c_data       (i2c_data),
        .i2c_data_valid (i2c_data_valid),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_last        (rd_last),
        .ovf_clr        (ovf_clr),
        .level          (level),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow),
        .frame_done     (frame_done)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    logic [8:0] mq[$];      // {last, byte}, head at index 0
    bit         m_prev_rdy;
    int         m_len;      // frame length, 0 = untagged streaming
    int         m_pos;      // bytes already seen in the current frame
    bit         m_ovf;
    bit         m_fd;

    // Applies the inputs that the coming clock edge will sample.
    task automatic model_cycle();
        bit rise, was_full, do_pop, last;
        if (!rst_n) begin
            mq.delete();
            m_prev_rdy = 0;
            m_len      = 0;
            m_pos      = 0;
            m_ovf      = 0;
            m_fd       = 0;
            return;
        end
        rise     = i2c_ready && !m_prev_rdy;
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() > 0) && rd_ready;
        if (rise) begin
            m_len = int'(i2c_data_bytes);
            m_pos = 0;
        end
        m_fd = 0;
        if (ovf_clr) m_ovf = 0;
        if (do_pop) void'(mq.pop_front());
        if (i2c_data_valid) begin
            last  = (m_len != 0) && (m_pos == m_len - 1);
            m_pos = last ? 0 : (m_pos + 1) % 16;
            if (was_full) m_ovf = 1;
            else begin
                mq.push_back({last, i2c_data});
                m_fd = last;
            end
        end
        m_prev_rdy = i2c_ready;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".level"},    32'(level),      32'(mq.size()));
        check({tag, ".empty"},    32'(empty),      32'(mq.size() == 0));
        check({tag, ".full"},     32'(full),       32'(mq.size() == DEPTH));
        check({tag, ".rd_valid"}, 32'(rd_valid),   32'(mq.size() != 0));
        check({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
        check({tag, ".frame_done"}, 32'(frame_done), 32'(m_fd));
        if (mq.size() != 0) begin
            check({tag, ".rd_data"}, 32'(rd_data), 32'(mq[0][7:0]));
            check({tag, ".rd_last"}, 32'(rd_last), 32'(mq[0][8]));
        end
    endtask

    // One clock: model update, edge, sample 1 ns later, compare.
    task automatic tick(input string tag);
        model_cycle();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic cyc(input string tag, input bit v, input logic [7:0] d, input bit rr);
        i2c_data_valid = v;
        i2c_data       = d;
        rd_ready       = rr;
        tick(tag);
        i2c_data_valid = 1'b0;
        rd_ready       = 1'b0;
    endtask

    // Lower i2c_ready for a cycle, then raise it with a new frame length.
    task automatic new_frame(input string tag, input logic [3:0] n);
        i2c_ready = 1'b0;
        cyc(tag, 0, 8'h00, 0);
        i2c_ready      = 1'b1;
        i2c_data_bytes = n;
    endtask

    initial begin
        int fd_cnt;
        rst_n          = 1'b0;
        i2c_ready      = 1'b0;
        i2c_data_bytes = 4'd0;
        i2c_data       = 8'h00;
        i2c_data_valid = 1'b0;
        rd_ready       = 1'b0;
        ovf_clr        = 1'b0;

        // ---- reset ----
        cyc("reset", 0, 8'h00, 0);
        cyc("reset", 0, 8'h00, 0);
        check("reset.empty", 32'(empty), 32'd1);
        check("reset.level", 32'(level), 32'd0);
        rst_n = 1'b1;

        // ---- frame tagging: 7-byte frame ----
        i2c_data_bytes = 4'd7;
        i2c_ready      = 1'b1;
        for (int i = 0; i < 7; i++) cyc("t1.wr", 1, 8'hF0 + 8'(i), 0);
        check("t1.level", 32'(level), 32'd7);
        check("t1.frame_done", 32'(frame_done), 32'd1);
        cyc("t1.idle", 0, 8'h00, 0);
        check("t1.frame_done_end", 32'(frame_done), 32'd0);
        for (int i = 0; i < 7; i++) begin
            check("t1.drain_data", 32'(rd_data), 32'hF0 + 32'(i));
            check("t1.drain_last", 32'(rd_last), 32'(i == 6));
            cyc("t1.rd", 0, 8'h00, 1);
        end
        check("t1.empty", 32'(empty), 32'd1);

        // ---- overflow with untagged streaming ----
        new_frame("t2.start", 4'd0);
        for (int i = 0; i < 18; i++) cyc("t2.wr", 1, 8'(i), 0);
        check("t2.full", 32'(full), 32'd1);
        check("t2.overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("t2.drain_data", 32'(rd_data), 32'(i));
            check("t2.drain_last", 32'(rd_last), 32'd0);
            cyc("t2.rd", 0, 8'h00, 1);
        end
        ovf_clr = 1'b1;
        cyc("t2.clr", 0, 8'h00, 0);
        ovf_clr = 1'b0;
        check("t2.ovf_cleared", 32'(overflow), 32'd0);

        // ---- simultaneous write/pop across pointer wrap ----
        for (int i = 0; i < 3; i++) cyc("t3.fill", 1, 8'h30 + 8'(i), 0);
        for (int i = 0; i < 20; i++) begin
            check("t3.head", 32'(rd_data), 32'h30 + 32'(i));
            cyc("t3.rw", 1, 8'h33 + 8'(i), 1);
            check("t3.level", 32'(level), 32'd3);
        end
        for (int i = 0; i < 3; i++) cyc("t3.drain", 0, 8'h00, 1);

        // ---- back-to-back 2-byte frames ----
        new_frame("t4.start", 4'd2);
        fd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc("t4.wr", 1, 8'hA0 + 8'(i), 0);
            fd_cnt += int'(frame_done);
        end
        check("t4.fd_count", 32'(fd_cnt), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check("t4.drain_data", 32'(rd_data), 32'hA0 + 32'(i));
            check("t4.drain_last", 32'(rd_last), 32'(i == 1 || i == 3));
            cyc("t4.rd", 0, 8'h00, 1);
        end
        // Restart after one byte with a 3-byte frame.
        new_frame("t4b.start", 4'd2);
        cyc("t4b.a0", 1, 8'hA0, 0);
        new_frame("t4b.restart", 4'd3);
        for (int i = 0; i < 3; i++) cyc("t4b.wr", 1, 8'hB0 + 8'(i), 0);
        check("t4b.level", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t4b.drain_last", 32'(rd_last), 32'(i == 3));
            cyc("t4b.rd", 0, 8'h00, 1);
        end

        // ---- full with read in the same cycle ----
        new_frame("t5.start", 4'd0);
        for (int i = 0; i < 16; i++) cyc("t5.fill", 1, 8'h50 + 8'(i), 0);
        cyc("t5.full_rw", 1, 8'hEE, 1);
        check("t5.level", 32'(level), 32'd15);
        check("t5.overflow", 32'(overflow), 32'd1);
        check("t5.head", 32'(rd_data), 32'h51);
        for (int i = 0; i < 15; i++) cyc("t5.drain", 0, 8'h00, 1);
        ovf_clr = 1'b1;
        cyc("t5.clr", 0, 8'h00, 0);
        ovf_clr = 1'b0;

        // ---- reset mid-frame: 3-byte frames, 5 bytes -> 5 entries, fcnt 2 ----
        new_frame("t6.start", 4'd3);
        for (int i = 0; i < 5; i++) cyc("t6.wr", 1, 8'hC0 + 8'(i), 0);
        check("t6.level_pre", 32'(level), 32'd5);
        rst_n     = 1'b0;
        i2c_ready = 1'b0;
        cyc("t6.rst", 0, 8'h00, 0);
        rst_n = 1'b1;
        check("t6.empty", 32'(empty), 32'd1);
        check("t6.level", 32'(level), 32'd0);
        i2c_ready      = 1'b1;
        i2c_data_bytes = 4'd4;
        for (int i = 0; i < 4; i++) cyc("t6.wr2", 1, 8'hD0 + 8'(i), 0);
        check("t6.fd", 32'(frame_done), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t6.drain_last", 32'(rd_last), 32'(i == 3));
            cyc("t6.rd", 0, 8'h00, 1);
        end

        // ---- randomized traffic ----
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) i2c_ready = ~i2c_ready;
            if ($urandom_range(0, 9) == 0)  i2c_data_bytes = 4'($urandom_range(0, 15));
            ovf_clr = ($urandom_range(0, 19) == 0);
            rst_n   = ($urandom_range(0, 599) != 0);
            cyc("rnd", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0 ? 0 : 1));
            ovf_clr = 1'b0;
            rst_n   = 1'b1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
